serial_to_parallel: RTL

- Deserializer: collects a stream of single-bit serial samples into WIDTH-bit words.
- Presents each completed word on a one-entry output register with a valid/ready handshake.
- Sits on the receive side of the serial link, downstream of the team's parallel-to-serial transmitter; matches its LSB-first, one-bit-per-valid-cycle convention.
- Reports dropped words (overflow) and, optionally, abandoned partial frames.

---
 rtl/serial_to_parallel.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel
// Description : Deserializer that packs one serial bit per valid cycle into
//               WIDTH-bit words on a one-entry valid/ready output register.
//               Optional partial-word idle timeout enabled by S2P_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_to_parallel #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       serial_valid,
    input  logic                       serial_data,
    output logic                       parallel_valid,
    output logic [WIDTH-1:0]           parallel_data,
    input  logic                       parallel_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overflow,
    output logic                       frame_error
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int IW  = $clog2(WIDTH);

    localparam logic [0:0]     c_IDLE     = 1'b0;
    localparam logic [0:0]     c_COLLECT  = 1'b1;
    localparam logic [BCW-1:0] c_LAST_BIT = BCW'(WIDTH - 1);

    if (WIDTH < 2 || TIMEOUT < 1) begin : g_bad_config
        $error("serial_to_parallel: WIDTH must be >= 2 and TIMEOUT >= 1");
    end

    logic [0:0]       state_q, state_d;
    logic [BCW-1:0]   bit_count_q, bit_count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             pvalid_q, pvalid_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             overflow_q, overflow_d;

    logic [IW-1:0]    w_pos;
    logic [WIDTH-1:0] w_word;
    logic             w_word_done;
    logic             w_timeout;

    // Slot for the arriving bit, and the shift image with that bit merged in.
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_pos = IW'(WIDTH - 1) - IW'(bit_count_q);
        end else begin
            w_pos = IW'(bit_count_q);
        end
        w_word        = shift_q;
        w_word[w_pos] = serial_data;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_IDLE;
            bit_count_q <= '0;
            shift_q     <= '0;
            pvalid_q    <= 1'b0;
            pdata_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_count_q <= bit_count_d;
            shift_q     <= shift_d;
            pvalid_q    <= pvalid_d;
            pdata_q     <= pdata_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        bit_count_d = bit_count_q;
        shift_d     = shift_q;
        case (state_q)
            c_IDLE: begin
                if (serial_valid) begin
                    state_d     = c_COLLECT;
                    bit_count_d = BCW'(1);
                    shift_d     = w_word;
                end
            end
            default: begin
                if (serial_valid) begin
                    if (bit_count_q == c_LAST_BIT) begin
                        state_d     = c_IDLE;
                        bit_count_d = '0;
                        shift_d     = '0;
                    end else begin
                        bit_count_d = bit_count_q + 1'b1;
                        shift_d     = w_word;
                    end
                end else if (w_timeout) begin
                    state_d     = c_IDLE;
                    bit_count_d = '0;
                    shift_d     = '0;
                end
            end
        endcase
    end

    // Output logic: completion detect and the one-entry output register
    always_comb begin
        w_word_done = (state_q == c_COLLECT) && serial_valid && (bit_count_q == c_LAST_BIT);
        pvalid_d    = pvalid_q & ~parallel_ready;
        pdata_d     = pdata_q;
        overflow_d  = 1'b0;
        if (w_word_done) begin
            // A word can only land if the slot is empty or drains this same edge.
            if (!pvalid_q || parallel_ready) begin
                pvalid_d = 1'b1;
                pdata_d  = w_word;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

`ifdef S2P_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT + 1);

    logic [GW-1:0] gap_q, gap_d;
    logic          frame_error_q;

    // Counts consecutive idle cycles inside a partial word; a valid bit always wins.
    always_comb begin
        gap_d     = '0;
        w_timeout = 1'b0;
        if (state_q == c_COLLECT && !serial_valid) begin
            if (gap_q == GW'(TIMEOUT - 1)) begin
                w_timeout = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q         <= '0;
            frame_error_q <= 1'b0;
        end else begin
            gap_q         <= gap_d;
            frame_error_q <= w_timeout;
        end
    end

    assign frame_error = frame_error_q;
`else
    assign w_timeout   = 1'b0;
    assign frame_error = 1'b0;
`endif

    assign parallel_valid = pvalid_q;
    assign parallel_data  = pdata_q;
    assign bit_count      = bit_count_q;
    assign overflow       = overflow_q;

endmodule
`default_nettype wire
